video_timing_gen: RTL and testbench

//  Driving end of the object raster interface. Sweeps 720p raster counters, drives signed hpos/vpos and one-cycle

---
 rtl/video_timing_gen.sv | 122 ++++++++++++
 tb/tb_video_timing_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator for the object layer: sweeps h/v counters, hands signed positions to
// objects, and registers their merged pixel back out with syncs and data enable.
module video_timing_gen #(
    parameter int unsigned HRES     = 1280,
    parameter int unsigned HFP      = 110,
    parameter int unsigned HSW      = 40,
    parameter int unsigned HBP      = 220,
    parameter int unsigned VRES     = 720,
    parameter int unsigned VFP      = 5,
    parameter int unsigned VSW      = 5,
    parameter int unsigned VBP      = 20,
    parameter logic        SYNC_POL = 1'b1,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    input  logic [7:0]         pixel_in [0:2],
    input  logic               active_in,
    output logic [7:0]         rgb [0:2],
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [15:0]        frame_cnt
);

    localparam int unsigned HTOTAL = HRES + HFP + HSW + HBP;
    localparam int unsigned VTOTAL = VRES + VFP + VSW + VBP;

    localparam logic [11:0] HRES_W   = 12'(HRES);
    localparam logic [11:0] VRES_W   = 12'(VRES);
    localparam logic [11:0] HTOT_W   = 12'(HTOTAL);
    localparam logic [11:0] VTOT_W   = 12'(VTOTAL);
    localparam logic [11:0] HMAX_W   = 12'(HTOTAL - 1);
    localparam logic [11:0] VMAX_W   = 12'(VTOTAL - 1);
    localparam logic [11:0] HS_BEG_W = 12'(HRES + HFP);
    localparam logic [11:0] HS_END_W = 12'(HRES + HFP + HSW);
    localparam logic [11:0] VS_BEG_W = 12'(VRES + VFP);
    localparam logic [11:0] VS_END_W = 12'(VRES + VFP + VSW);

    logic [11:0] r_hcnt;
    logic [11:0] r_vcnt;
    logic        r_fsync;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_rgb [0:2];
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;

    logic        w_de0;
    logic        w_hs0;
    logic        w_vs0;
    logic        w_frame_end;

    // Blanking maps to negative positions so objects never see a false hit at 0.
    assign hpos = (r_hcnt < HRES_W) ? $signed(r_hcnt) : $signed(r_hcnt - HTOT_W);
    assign vpos = (r_vcnt < VRES_W) ? $signed(r_vcnt) : $signed(r_vcnt - VTOT_W);

    assign w_de0       = (r_hcnt < HRES_W) && (r_vcnt < VRES_W);
    assign w_hs0       = (r_hcnt >= HS_BEG_W) && (r_hcnt < HS_END_W);
    assign w_vs0       = (r_vcnt >= VS_BEG_W) && (r_vcnt < VS_END_W);
    assign w_frame_end = (r_hcnt == 12'd0) && (r_vcnt == VRES_W);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= 12'd0;
            r_vcnt <= 12'd0;
        end else if (r_hcnt == HMAX_W) begin
            r_hcnt <= 12'd0;
            r_vcnt <= (r_vcnt == VMAX_W) ? 12'd0 : r_vcnt + 12'd1;
        end else begin
            r_hcnt <= r_hcnt + 12'd1;
        end
    end

    // Strobe lands one clock into the first blanking line, with the frame count update.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsync     <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_fsync <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_rgb[i] <= 8'd0;
            end
            r_de    <= 1'b0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!w_de0) begin
                    r_rgb[i] <= 8'd0;
                end else if (active_in) begin
                    r_rgb[i] <= pixel_in[i];
                end else begin
                    r_rgb[i] <= BG_COLOR[8*i +: 8];
                end
            end
            r_de    <= w_de0;
            r_hsync <= w_hs0 ^ ~SYNC_POL;
            r_vsync <= w_vs0 ^ ~SYNC_POL;
        end
    end

    assign fsync     = r_fsync;
    assign frame_cnt = r_frame_cnt;
    assign rgb       = r_rgb;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster: a position-from-cycle-count model checked every
// cycle, plus literal timing points that pin the model.
module tb_video_timing_gen;

    localparam int HRES = 16, HFP = 3, HSW = 4, HBP = 5;
    localparam int VRES = 10, VFP = 2, VSW = 3, VBP = 4;
    localparam int HT = HRES + HFP + HSW + HBP;   // 28
    localparam int VT = VRES + VFP + VSW + VBP;   // 19
    localparam int FRAME = HT * VT;               // 532
    localparam int OBJ_W = 6, OBJ_H = 4;
    localparam logic [23:0] BG = 24'h123456;
    localparam logic [23:0] OBJ_RGB = 24'hEFE62E;  // R G B

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [11:0] hpos, vpos;
    logic              fsync, hsync, vsync, de, active_in;
    logic [7:0]        pix [0:2];
    logic [7:0]        rgb [0:2];
    logic [15:0]       frame_cnt;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int de_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    bit first_run = 1'b1;

    always #5 clk = ~clk;

    video_timing_gen #(
        .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
        .SYNC_POL(1'b1), .BG_COLOR(BG)
    ) dut (
        .pixel_clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .fsync(fsync),
        .pixel_in(pix), .active_in(active_in), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_cnt(frame_cnt)
    );

    // Object layer: a box at the origin, plus a deliberately bright "hit" all over blanking.
    always_comb begin
        logic in_box;
        in_box = (hpos >= 0) && (hpos < OBJ_W) && (vpos >= 0) && (vpos < OBJ_H);
        active_in = in_box || (hpos < 0) || (vpos < 0);
        pix[0] = in_box ? OBJ_RGB[7:0]   : 8'hFF;
        pix[1] = in_box ? OBJ_RGB[15:8]  : 8'hFF;
        pix[2] = in_box ? OBJ_RGB[23:16] : 8'hFF;
    end

    // Clocks since reset release = raster position of the counters.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic int pos_h(input int t);
        return t % HT;
    endfunction

    function automatic int pos_v(input int t);
        return (t / HT) % VT;
    endfunction

    // Every cycle: outputs registered from position k-1, positions from position k.
    always @(negedge clk) begin
        int h, v, ph, pv, fbase, fexp;
        logic [11:0] eh, ev;
        logic        e_de, e_hs, e_vs, e_fs, in_box;
        logic [23:0] e_rgb;
        h = pos_h(k);
        v = pos_v(k);
        eh = 12'(h < HRES ? h : h - HT);
        ev = 12'(v < VRES ? v : v - VT);
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 24'h0;
        if (k > 0) begin
            ph = pos_h(k - 1);
            pv = pos_v(k - 1);
            e_de = (ph < HRES) && (pv < VRES);
            e_hs = (ph >= HRES + HFP) && (ph < HRES + HFP + HSW);
            e_vs = (pv >= VRES + VFP) && (pv < VRES + VFP + VSW);
            in_box = (ph < OBJ_W) && (pv < OBJ_H);
            e_rgb = !e_de ? 24'h0 : in_box ? OBJ_RGB : BG;
        end
        e_fs = (h == 1) && (v == VRES);
        fbase = VRES * HT + 1;
        fexp = (k >= fbase) ? (k - fbase) / FRAME + 1 : 0;
        chk("hpos", {20'b0, $unsigned(hpos)}, {20'b0, eh});
        chk("vpos", {20'b0, $unsigned(vpos)}, {20'b0, ev});
        chk("de", {31'b0, de}, {31'b0, e_de});
        chk("hsync", {31'b0, hsync}, {31'b0, e_hs});
        chk("vsync", {31'b0, vsync}, {31'b0, e_vs});
        chk("rgb", {8'b0, rgb[2], rgb[1], rgb[0]}, {8'b0, e_rgb});
        chk("fsync", {31'b0, fsync}, {31'b0, e_fs});
        chk("frame_cnt", {16'b0, frame_cnt}, 32'(16'(fexp)));
        if (first_run && rst_n) begin
            if (k >= 1 && k <= FRAME) begin
                de_cnt += int'(de);
                vs_cnt += int'(vsync);
            end
            if (k <= 3 * FRAME) fs_cnt += int'(fsync);
        end
    end

    task automatic wait_k(input int t);
        int guard;
        guard = 0;
        while (k < t && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_k_bound", 32'(k), 32'(t));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // Reset state, hand-computed
        chk("rst_de", {31'b0, de}, 32'd0);
        chk("rst_hsync", {31'b0, hsync}, 32'd0);
        chk("rst_vsync", {31'b0, vsync}, 32'd0);
        chk("rst_hpos", {20'b0, $unsigned(hpos)}, 32'd0);
        chk("rst_rgb", {8'b0, rgb[2], rgb[1], rgb[0]}, 32'd0);
        rst_n = 1'b1;
        wait_k(1);
        chk("lit_de_rise", {31'b0, de}, 32'd1);
        chk("lit_hpos1", {20'b0, $unsigned(hpos)}, 32'd1);
        wait_k(6);
        chk("lit_obj_rgb", {8'b0, rgb[2], rgb[1], rgb[0]}, 32'h00EFE62E);
        wait_k(8);
        chk("lit_bg_rgb", {8'b0, rgb[2], rgb[1], rgb[0]}, 32'h00123456);
        wait_k(16);
        chk("lit_hpos_neg", {20'b0, $unsigned(hpos)}, 32'hFF4);  // -12
        chk("lit_de_last", {31'b0, de}, 32'd1);
        wait_k(17);
        chk("lit_de_fall", {31'b0, de}, 32'd0);
        wait_k(19);
        chk("lit_hs_pre", {31'b0, hsync}, 32'd0);
        wait_k(20);
        chk("lit_hs_rise", {31'b0, hsync}, 32'd1);
        wait_k(23);
        chk("lit_hs_last", {31'b0, hsync}, 32'd1);
        wait_k(24);
        chk("lit_hs_fall", {31'b0, hsync}, 32'd0);
        wait_k(48);
        chk("lit_hs_period", {31'b0, hsync}, 32'd1);
        wait_k(280);
        chk("lit_vpos_blank", {20'b0, $unsigned(vpos)}, 32'hFF7);  // -9
        chk("lit_fs_pre", {31'b0, fsync}, 32'd0);
        wait_k(281);
        chk("lit_fsync", {31'b0, fsync}, 32'd1);
        chk("lit_fcnt1", {16'b0, frame_cnt}, 32'd1);
        wait_k(282);
        chk("lit_fs_one", {31'b0, fsync}, 32'd0);
        wait_k(3 * FRAME + 1);
        chk("lit_de_cycles", 32'(de_cnt), 32'd160);
        chk("lit_vs_cycles", 32'(vs_cnt), 32'd84);
        chk("lit_fs_pulses", 32'(fs_cnt), 32'd3);
        chk("lit_fcnt3", {16'b0, frame_cnt}, 32'd3);
        // Mid-frame async reset on line 5
        wait_k(3 * FRAME + 150);
        first_run = 1'b0;
        chk("pre_rst_de", {31'b0, de}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_de", {31'b0, de}, 32'd0);
        chk("async_hpos", {20'b0, $unsigned(hpos)}, 32'd0);
        chk("async_vpos", {20'b0, $unsigned(vpos)}, 32'd0);
        chk("async_fcnt", {16'b0, frame_cnt}, 32'd0);
        chk("async_rgb", {8'b0, rgb[2], rgb[1], rgb[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_k(1);
        chk("rel_de_rise", {31'b0, de}, 32'd1);
        chk("rel_vpos", {20'b0, $unsigned(vpos)}, 32'd0);
        wait_k(281);
        chk("rel_fsync", {31'b0, fsync}, 32'd1);
        chk("rel_fcnt", {16'b0, frame_cnt}, 32'd1);
        wait_k(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
